// File: rtl/cpu_pkg.sv
// Shared CPU constants used by the fetch stage and its instruction buffer.
package cpu_pkg;

  localparam int          ADDRESS_SIZE = 32;
  localparam int          DATA_SIZE    = 32;
  localparam logic [31:0] RESET_PC     = 32'h8002_0000;
  localparam logic [1:0]  ACC_WORD     = 2'b00;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer for the fetch stage: DEPTH entries of {pc, insn}, flush wins over push/pop.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       din_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{PW{1'b0}}, push_i} - {{PW{1'b0}}, pop_i};
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_i && !pop_i && !flush_i && full_o));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop_i && !flush_i && empty_o));

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues one-word reads, buffers returned words and hands
// {pc, insn} to decode with a valid/stall handshake; redirect flushes everything in flight.
module fetch_unit #(
  parameter int                      ADDRESS_SIZE = cpu_pkg::ADDRESS_SIZE,
  parameter int                      DATA_SIZE    = cpu_pkg::DATA_SIZE,
  parameter logic [ADDRESS_SIZE-1:0] RESET_PC     = cpu_pkg::RESET_PC,
  parameter int                      FIFO_DEPTH   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic                    mem_en,
  output logic                    mem_wren,
  output logic [1:0]              mem_acc_size,
  input  logic [DATA_SIZE-1:0]    mem_d_out,
  input  logic                    mem_busy,
  input  logic                    redirect,
  input  logic [ADDRESS_SIZE-1:0] redirect_pc,
  input  logic                    stall,
  output logic                    insn_valid,
  output logic [DATA_SIZE-1:0]    insn,
  output logic [ADDRESS_SIZE-1:0] insn_pc
);

  import cpu_pkg::*;

  localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int            EW      = ADDRESS_SIZE + DATA_SIZE;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);

  logic [ADDRESS_SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDRESS_SIZE-1:0] inflight_pc_q;
  logic                    inflight_q, inflight_d;

  logic          issue;
  logic          resp_vld;
  logic          pop;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  logic [EW-1:0] fifo_head;
  logic [CW:0]   credit;

  always_comb begin
    credit   = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    issue    = !reset && !mem_busy && !redirect && (credit < DEPTH_C);
    // A response landing in a redirect cycle belongs to the old path.
    resp_vld = inflight_q && !redirect;

    insn_valid = !fifo_empty || resp_vld;
    if (!fifo_empty)   {insn_pc, insn} = fifo_head;
    else if (resp_vld) {insn_pc, insn} = {inflight_pc_q, mem_d_out};
    else               {insn_pc, insn} = '0;

    pop       = insn_valid && !stall && !redirect;
    fifo_pop  = pop && !fifo_empty;
    // Empty buffer plus same-cycle pop: the word goes straight through to decode.
    fifo_push = resp_vld && !(fifo_empty && pop);

    inflight_d = issue;
    if (redirect)   fetch_pc_d = redirect_pc & ~ADDRESS_SIZE'(3);
    else if (issue) fetch_pc_d = fetch_pc_q + ADDRESS_SIZE'(4);
    else            fetch_pc_d = fetch_pc_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) inflight_pc_q <= fetch_pc_q;
  end

  assign mem_addr     = fetch_pc_q;
  assign mem_en       = issue;
  assign mem_wren     = 1'b0;
  assign mem_acc_size = ACC_WORD;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (redirect),
    .din_i   ({inflight_pc_q, mem_d_out}),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

endmodule
